iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the ex stage. It is the successor of the fixed 32-bit divider.
- Adds a WIDTH parameter, cancel in every busy state, a busy flag, a divide-by-zero flag and optional early-out.
- ex drives start and operands, stalls the pipeline while busy, and captures {remainder, quotient} into hi/lo when ready is high.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1), localparam; width of the iteration counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start_input  in  1  request; held high until ready is seen, then dropped
- cancel_input  in  1  abort (pipeline flush)
- is_sign_div_input  in  1  1 = signed (two's complement), 0 = unsigned
- data1_input  in  WIDTH  dividend
- data2_input  in  WIDTH  divisor
- result_output  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
- ready_output  out  1  result valid
- busy_output  out  1  high in BY_ZERO and ON
- div_by_zero_output  out  1  current result came from a zero divisor

Behaviour:
- Reset (reset=0, async): state FREE, all outputs 0, counter 0, internal registers 0.
- All outputs are registered.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - start=1, cancel=0, divisor=0 → BY_ZERO.
  - start=1, cancel=0, otherwise → ON. Operands and sign mode are latched on this edge (e0). Later operand changes are ignored.
  - Signed mode: operands are latched as absolute values; quotient-negate and remainder-negate flags are recorded.
- BY_ZERO: next edge → END with result=0 and div_by_zero=1. Ready therefore rises at e0+1.
- ON:
  - Exactly N iterations, one per cycle. N=WIDTH without the optional feature.
  - Each iteration: partial remainder = {rem, next dividend bit}. Subtract the divisor; if no borrow, keep the difference and shift in quotient bit 1, else shift in 0.
  - At the edge completing the Nth iteration → END, ready=1, result written. Ready therefore rises at e0+N.
- Sign fix on entry to END:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MIN_INT / -1 gives quotient=MIN_INT (wraps) and remainder=0, with no flag.
- END:
  - Ready and result are held stable while start=1.
  - start=0 → FREE next edge; ready, result and div_by_zero are cleared to 0.
- Cancel:
  - cancel=1 in BY_ZERO, ON or END → FREE next edge with outputs cleared. Cancel has priority over completion on the same edge.
  - cancel=1 together with start in FREE → remains FREE.
- start is ignored outside FREE. A new division requires a return to FREE first, so the minimum gap is one FREE cycle.
- reset deasserted mid-operation: the state is lost; ex must re-issue.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - On the start edge the block counts leading zeros lz of |dividend| and pre-shifts the dividend left by lz.
  - N = WIDTH - lz.
  - Dividend 0 (divisor ≠ 0): FREE → END directly with result=0, so ready rises at e0.
  - Divisor 0 takes precedence over dividend 0.
- Undefined: N=WIDTH always and no leading-zero logic is built.
- Results are bit-identical with and without the macro; only latency differs.

Decomposition:
- The shared defines file holds:
  - state encodings DivFree, DivByZero, DivOn, DivEnd;
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop.
- Width macros are derived from WIDTH in the module.
- Sub-module iter_divider_lzc (parametrised leading-zero counter, WIDTH in, CNT_W out) is instantiated only under DIV_EARLY_OUT_EN.

Test Plan:
- WIDTH=32 unsigned 100/7, start at e0 → ready at e0+32, quotient=14, remainder=2; held 5 cycles with start high; start dropped → ready=0, result=0 next edge.
- Signed -7/2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7/-2 → quotient=0xFFFFFFFD, remainder=1.
- Divisor 0 (dividend 0x1234) → busy for 1 cycle, ready at e0+1, div_by_zero=1, result=0.
- Cancel asserted during iteration 10 → FREE next edge, ready never asserted. A following 9/3 start → quotient=3, remainder=0, ready at its own e0+32.
- Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- With DIV_EARLY_OUT_EN: unsigned 5/1 → ready at e0+3, quotient=5. 0/9 → ready at e0, result 0. All earlier vectors match non-EN results exactly.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// -----------------------------------------------------------------------------
// iter_divider_pkg
// Shared definitions for the iterative radix-2 restoring divider:
//   - state encoding of the divider FSM (DivFree, DivByZero, DivOn, DivEnd)
//   - result-ready and start/stop level constants
//   - helper for the iteration-counter width
// Optional feature macro used by the divider files: DIV_EARLY_OUT_EN.
// -----------------------------------------------------------------------------
package iter_divider_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'd0,
        DivByZero = 2'd1,
        DivOn     = 2'd2,
        DivEnd    = 2'd3
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Counter must be able to hold the full iteration count WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// -----------------------------------------------------------------------------
// iter_divider_if
// Request/result bundle between the ex stage (master) and the divider (slave).
//   start_input         request, held until ready is seen
//   cancel_input        abort (pipeline flush)
//   is_sign_div_input   1 = signed, 0 = unsigned
//   data1_input         dividend, WIDTH bits
//   data2_input         divisor, WIDTH bits
//   result_output       {remainder, quotient}, 2*WIDTH bits
//   ready_output        result valid
//   busy_output         divider occupied (BY_ZERO / ON)
//   div_by_zero_output  current result came from a zero divisor
// -----------------------------------------------------------------------------
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic                   start_input;
    logic                   cancel_input;
    logic                   is_sign_div_input;
    logic [WIDTH-1:0]       data1_input;
    logic [WIDTH-1:0]       data2_input;
    logic [2*WIDTH-1:0]     result_output;
    logic                   ready_output;
    logic                   busy_output;
    logic                   div_by_zero_output;

    modport master (
        output start_input,
        output cancel_input,
        output is_sign_div_input,
        output data1_input,
        output data2_input,
        input  result_output,
        input  ready_output,
        input  busy_output,
        input  div_by_zero_output
    );

    modport slave (
        input  start_input,
        input  cancel_input,
        input  is_sign_div_input,
        input  data1_input,
        input  data2_input,
        output result_output,
        output ready_output,
        output busy_output,
        output div_by_zero_output
    );
endinterface

// File: rtl/iter_divider_lzc.sv
// -----------------------------------------------------------------------------
// iter_divider_lzc
// Combinational leading-zero counter used by the divider's early-out path
// (only instantiated when DIV_EARLY_OUT_EN is defined).
//   value  in   WIDTH   operand to inspect
//   count  out  CNT_W   number of leading zeros; WIDTH when value == 0
// -----------------------------------------------------------------------------
module iter_divider_lzc
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // zero_above[i] is set when bit i and everything above it are zero, so the
    // number of set flags equals the leading-zero count.
    logic [WIDTH-1:0] zero_above;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_zero_above
            assign zero_above[gi] = ~|value[WIDTH-1:gi];
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + {{(CNT_W-1){1'b0}}, zero_above[i]};
        end
    end

endmodule

// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
// Multi-cycle radix-2 restoring divider for the ex stage, signed or unsigned.
// One quotient bit per cycle; result {remainder, quotient} is held while start
// stays high and cleared once start drops. Cancel aborts from any busy state.
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-low reset
//   bus     slave side of iter_divider_if (start/cancel/operands in,
//           result/ready/busy/div_by_zero out, all outputs registered)
// Optional feature: DIV_EARLY_OUT_EN skips leading-zero iterations of the
// dividend (latency WIDTH - lz, zero dividend finishes on the start edge).
// Results are identical with and without the feature.
// -----------------------------------------------------------------------------
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    iter_divider_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int RES_W = 2 * WIDTH;

    div_state_e        state_reg;
    logic [WIDTH-1:0]  dvd_reg;      // dividend being shifted out, quotient shifted in
    logic [WIDTH-1:0]  dvs_reg;      // |divisor|
    logic [WIDTH-1:0]  rem_reg;      // partial remainder
    logic [CNT_W-1:0]  cnt_reg;      // iterations still to run
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic [RES_W-1:0]  result_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              dz_reg;

    // ---------------- operand preparation (used on the start edge) ----------
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;
    logic              divisor_zero;
    logic [WIDTH-1:0]  start_dvd;
    logic [CNT_W-1:0]  iter_n;

    assign a_neg        = bus.is_sign_div_input & bus.data1_input[WIDTH-1];
    assign b_neg        = bus.is_sign_div_input & bus.data2_input[WIDTH-1];
    assign abs_a        = a_neg ? (~bus.data1_input + 1'b1) : bus.data1_input;
    assign abs_b        = b_neg ? (~bus.data2_input + 1'b1) : bus.data2_input;
    assign divisor_zero = (bus.data2_input == '0);

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0]  lz;
    logic              dividend_zero;

    iter_divider_lzc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_lzc (
        .value (abs_a),
        .count (lz)
    );

    // Pre-shifting by lz means the first remaining iteration consumes the
    // dividend's top set bit; the shifted-out zeros never contribute.
    assign dividend_zero = (bus.data1_input == '0);
    assign start_dvd     = abs_a << lz;
    assign iter_n        = CNT_W'(WIDTH) - lz;
`else
    assign start_dvd     = abs_a;
    assign iter_n        = CNT_W'(WIDTH);
`endif

    // ---------------- one restoring-division step ----------------------------
    logic [WIDTH:0]    partial;
    logic [WIDTH:0]    diff;
    logic              q_bit;
    logic [WIDTH-1:0]  rem_step;
    logic [WIDTH-1:0]  dvd_step;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;
    logic              last_iter;

    assign partial   = {rem_reg, dvd_reg[WIDTH-1]};
    assign diff      = partial - {1'b0, dvs_reg};
    assign q_bit     = ~diff[WIDTH];              // no borrow -> subtract succeeds
    // Without subtraction partial < divisor, so its top bit is always zero.
    assign rem_step  = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign dvd_step  = {dvd_reg[WIDTH-2:0], q_bit};
    // MIN_INT / -1 falls out naturally: |MIN_INT| is MIN_INT unsigned, signs
    // differ twice so no negate, and the quotient wraps to MIN_INT.
    assign quo_fix   = neg_q_reg ? (~dvd_step + 1'b1) : dvd_step;
    assign rem_fix   = neg_r_reg ? (~rem_step + 1'b1) : rem_step;
    assign last_iter = (cnt_reg == CNT_W'(1));

    // ---------------- control FSM with registered outputs -------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= DivFree;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
            ready_reg  <= DivResultNotReady;
            busy_reg   <= 1'b0;
            dz_reg     <= 1'b0;
        end else begin
            case (state_reg)
                DivFree: begin
                    if (bus.start_input == DivStart && !bus.cancel_input) begin
                        if (divisor_zero) begin
                            state_reg <= DivByZero;
                            busy_reg  <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        end else if (dividend_zero) begin
                            state_reg  <= DivEnd;
                            result_reg <= '0;
                            ready_reg  <= DivResultReady;
`endif
                        end else begin
                            state_reg <= DivOn;
                            busy_reg  <= 1'b1;
                            dvd_reg   <= start_dvd;
                            dvs_reg   <= abs_b;
                            rem_reg   <= '0;
                            cnt_reg   <= iter_n;
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
                        end
                    end
                end

                DivByZero: begin
                    busy_reg <= 1'b0;
                    if (bus.cancel_input) begin
                        state_reg <= DivFree;
                    end else begin
                        state_reg  <= DivEnd;
                        result_reg <= '0;
                        ready_reg  <= DivResultReady;
                        dz_reg     <= 1'b1;
                    end
                end

                DivOn: begin
                    if (bus.cancel_input) begin
                        state_reg <= DivFree;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        dvd_reg <= dvd_step;
                        rem_reg <= rem_step;
                        cnt_reg <= cnt_reg - CNT_W'(1);
                        if (last_iter) begin
                            state_reg  <= DivEnd;
                            busy_reg   <= 1'b0;
                            ready_reg  <= DivResultReady;
                            result_reg <= {rem_fix, quo_fix};
                        end
                    end
                end

                DivEnd: begin
                    // Result is held for as long as ex keeps start asserted.
                    if (bus.cancel_input || bus.start_input == DivStop) begin
                        state_reg  <= DivFree;
                        ready_reg  <= DivResultNotReady;
                        result_reg <= '0;
                        dz_reg     <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= DivFree;
                end
            endcase
        end
    end

    assign bus.result_output      = result_reg;
    assign bus.ready_output       = ready_reg;
    assign bus.busy_output        = busy_reg;
    assign bus.div_by_zero_output = dz_reg;

endmodule

// File: tb/tb_iter_divider.sv
// -----------------------------------------------------------------------------
// tb_iter_divider
// Directed bench for iter_divider (WIDTH=32): a table of division vectors with
// hand-computed quotient/remainder/latency, plus hand-written sequences for
// cancel in ON / BY_ZERO / END, start+cancel in FREE and async reset.
// Latency column is chosen by DIV_EARLY_OUT_EN.
// -----------------------------------------------------------------------------
module tb_iter_divider;

    localparam int W = 32;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat_full;
        int          lat_eo;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    iter_divider_if #(.WIDTH(W)) bus ();

    iter_divider #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for ready after the start edge; lat = edges after e0, -1 on timeout.
    task automatic wait_ready(output int lat, output logic busy0);
        lat   = -1;
        busy0 = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(posedge clock);
            #1;
            if (k == 0) begin
                busy0 = bus.busy_output;
                // Operands must be latched; disturb them after the start edge.
                bus.data1_input       = $urandom;
                bus.data2_input       = $urandom;
                bus.is_sign_div_input = ~bus.is_sign_div_input;
            end
            if (bus.ready_output) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_div(input vec_t v, input int hold);
        int          lat;
        int          exp_lat;
        logic        busy0;
        logic [63:0] exp_res;
        int          held_ok;
`ifdef DIV_EARLY_OUT_EN
        exp_lat = v.lat_eo;
`else
        exp_lat = v.lat_full;
`endif
        exp_res = {v.r, v.q};
        @(negedge clock);
        bus.is_sign_div_input = v.sgn;
        bus.data1_input       = v.a;
        bus.data2_input       = v.b;
        bus.start_input       = 1'b1;
        @(posedge clock);
        wait_ready(lat, busy0);
        check({v.name, " latency"}, 64'(lat), 64'(exp_lat));
        check({v.name, " busy_after_start"}, 64'(busy0), 64'(exp_lat > 0));
        check({v.name, " result"}, bus.result_output, exp_res);
        check({v.name, " div_by_zero"}, 64'(bus.div_by_zero_output), 64'(v.dz));
        check({v.name, " busy_at_ready"}, 64'(bus.busy_output), 64'd0);
        held_ok = 1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock);
            #1;
            if (!bus.ready_output || bus.result_output !== exp_res) held_ok = 0;
        end
        if (hold > 0) check({v.name, " held_stable"}, 64'(held_ok), 64'd1);
        @(negedge clock);
        bus.start_input = 1'b0;
        @(posedge clock);
        #1;
        $display("div %s: a=%h b=%h sgn=%0d lat=%0d q=%h r=%h dz=%0d", v.name, v.a, v.b,
                 v.sgn, lat, exp_res[31:0], exp_res[63:32], v.dz);
        check({v.name, " ready_cleared"}, 64'(bus.ready_output), 64'd0);
        check({v.name, " result_cleared"}, bus.result_output, 64'd0);
        check({v.name, " dz_cleared"}, 64'(bus.div_by_zero_output), 64'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int          lat;
        logic        busy0;
        int          seen_ready;
        vec_t        v93;

        checks = 0;
        errors = 0;
        //          name         sgn a             b             q             r             dz  full eo
        vecs[0]  = '{"u100/7",   0, 32'd100,      32'd7,        32'd14,       32'd2,        0,  32, 7};
        vecs[1]  = '{"s-7/2",    1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0,  32, 3};
        vecs[2]  = '{"s7/-2",    1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        0,  32, 3};
        vecs[3]  = '{"u1234/0",  0, 32'h1234,     32'd0,        32'd0,        32'd0,        1,  1,  1};
        vecs[4]  = '{"u9/3",     0, 32'd9,        32'd3,        32'd3,        32'd0,        0,  32, 4};
        vecs[5]  = '{"sMIN/-1",  1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0,  32, 32};
        vecs[6]  = '{"uMAX/1",   0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        0,  32, 32};
        vecs[7]  = '{"u5/1",     0, 32'd5,        32'd1,        32'd5,        32'd0,        0,  32, 3};
        vecs[8]  = '{"u0/9",     0, 32'd0,        32'd9,        32'd0,        32'd0,        0,  32, 0};
        vecs[9]  = '{"s-100/7",  1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 0,  32, 7};
        vecs[10] = '{"s-100/-7", 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 0,  32, 7};
        vecs[11] = '{"u7/100",   0, 32'd7,        32'd100,      32'd0,        32'd7,        0,  32, 3};
        vecs[12] = '{"s0/-5",    1, 32'd0,        32'hFFFFFFFB, 32'd0,        32'd0,        0,  32, 0};
        vecs[13] = '{"s5/0",     1, 32'd5,        32'd0,        32'd0,        32'd0,        1,  1,  1};

        bus.start_input       = 1'b0;
        bus.cancel_input      = 1'b0;
        bus.is_sign_div_input = 1'b0;
        bus.data1_input       = '0;
        bus.data2_input       = '0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset ready", 64'(bus.ready_output), 64'd0);
        check("reset busy", 64'(bus.busy_output), 64'd0);
        check("reset result", bus.result_output, 64'd0);
        check("reset dz", 64'(bus.div_by_zero_output), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Table-driven vectors; the first one also checks the 5-cycle hold.
        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i], (i == 0) ? 5 : 1);
        end

        // Cancel during iteration 10 of a full-length division.
        @(negedge clock);
        bus.is_sign_div_input = 1'b0;
        bus.data1_input       = 32'hFFFFFFFF;
        bus.data2_input       = 32'd3;
        bus.start_input       = 1'b1;
        @(posedge clock);
        repeat (9) @(posedge clock);
        @(negedge clock);
        bus.cancel_input = 1'b1;
        bus.start_input  = 1'b0;
        @(posedge clock);
        #1;
        check("cancel_on busy", 64'(bus.busy_output), 64'd0);
        check("cancel_on ready", 64'(bus.ready_output), 64'd0);
        @(negedge clock);
        bus.cancel_input = 1'b0;
        seen_ready = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clock);
            #1;
            if (bus.ready_output || bus.busy_output) seen_ready = 1;
        end
        check("cancel_on stays_idle", 64'(seen_ready), 64'd0);
        $display("seq cancel_on: cancelled in iteration 10");
        v93 = '{"u9/3_after_cancel", 0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 32, 4};
        run_div(v93, 0);

        // Cancel in BY_ZERO.
        @(negedge clock);
        bus.data1_input = 32'h1234;
        bus.data2_input = 32'd0;
        bus.start_input = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.cancel_input = 1'b1;
        bus.start_input  = 1'b0;
        @(posedge clock);
        #1;
        check("cancel_bz ready", 64'(bus.ready_output), 64'd0);
        check("cancel_bz dz", 64'(bus.div_by_zero_output), 64'd0);
        check("cancel_bz busy", 64'(bus.busy_output), 64'd0);
        $display("seq cancel_bz: cancelled in BY_ZERO");
        @(negedge clock);
        bus.cancel_input = 1'b0;

        // Cancel in END, then start+cancel in FREE must stay idle.
        @(negedge clock);
        bus.is_sign_div_input = 1'b0;
        bus.data1_input       = 32'd50;
        bus.data2_input       = 32'd5;
        bus.start_input       = 1'b1;
        @(posedge clock);
        wait_ready(lat, busy0);
        check("cancel_end reached_ready", 64'(lat >= 0), 64'd1);
        check("cancel_end result", bus.result_output, {32'd0, 32'd10});
        @(negedge clock);
        bus.cancel_input = 1'b1;
        bus.data1_input  = 32'd50;
        bus.data2_input  = 32'd5;
        @(posedge clock);
        #1;
        check("cancel_end ready", 64'(bus.ready_output), 64'd0);
        check("cancel_end result_cleared", bus.result_output, 64'd0);
        seen_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            if (bus.ready_output || bus.busy_output) seen_ready = 1;
        end
        check("start_cancel_free idle", 64'(seen_ready), 64'd0);
        $display("seq cancel_end: cancelled in END, start+cancel held in FREE");
        @(negedge clock);
        bus.cancel_input = 1'b0;
        bus.start_input  = 1'b0;

        // Asynchronous reset in the middle of an operation.
        @(negedge clock);
        bus.data1_input = 32'hFFFFFFFF;
        bus.data2_input = 32'd3;
        bus.start_input = 1'b1;
        @(posedge clock);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset busy", 64'(bus.busy_output), 64'd0);
        check("async_reset ready", 64'(bus.ready_output), 64'd0);
        $display("seq async_reset: reset asserted mid-division");
        @(negedge clock);
        bus.start_input = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("after_reset busy", 64'(bus.busy_output), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
